dadda_prod_accum: RTL and testbench

- Downstream consumer of the dadda8x8 multiplier output.
- Takes a stream of 16-bit products under a valid/ready handshake and accumulates them into one wide sum per packet. A packet ends with a beat that has `in_last` set.
- Presents each packet's sum, beat count and overflow flag on a registered output handshake.
- This is the sequential multiply-accumulate back end placed after the combinational Dadda tree.

---
 rtl/dadda_prod_accum.sv | 180 ++++++++++++++++++
 tb/tb_dadda_prod_accum.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_prod_accum.sv
// -----------------------------------------------------------------------------
// dadda_prod_accum
//
// Sequential multiply-accumulate back end for the combinational dadda8x8
// multiplier. Unsigned products arrive one beat at a time under a
// valid/ready handshake and are summed into a wide accumulator. A beat with
// in_last set closes the packet: the packet sum, the beat count and a sticky
// overflow flag are then presented on a registered output handshake.
//
// Ports:
//   clk        input   1        system clock, rising-edge active
//   rst        input   1        asynchronous, active-high reset
//   in_valid   input   1        in_prod / in_last carry a beat
//   in_ready   output  1        block accepts a beat this cycle
//   in_prod    input   PROD_W   unsigned product from the multiplier
//   in_last    input   1        this beat closes the packet
//   flush      input   1        synchronous discard of the partial packet
//   out_valid  output  1        result registers hold a completed packet
//   out_ready  input   1        downstream accepts the result
//   out_sum    output  ACC_W    packet sum, modulo 2^ACC_W
//   out_count  output  COUNT_W  beats in the packet, saturating
//   out_ovf    output  1        a carry out of ACC_W occurred in the packet
//
// Parameters:
//   PROD_W   product width (16 for an 8x8 multiplier)
//   ACC_W    accumulator / result width, must be >= PROD_W
//   COUNT_W  width of the per-packet beat counter
// -----------------------------------------------------------------------------
module dadda_prod_accum #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_prod,
  input  logic               in_last,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  // ACCUM collects beats; HOLD presents a finished packet and blocks input
  // until the result has been taken.
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Saturating increment: the count sticks at all-ones rather than wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
    logic [COUNT_W-1:0] res;
    if (cnt == {COUNT_W{1'b1}}) begin
      res = cnt;
    end else begin
      res = cnt + COUNT_W'(1'b1);
    end
    return res;
  endfunction

  state_t             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [COUNT_W-1:0] cnt_q,       cnt_d;
  logic               ovf_q,       ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_ovf_q,   out_ovf_d;

  // One bit wider than the accumulator so the carry out is visible.
  logic [ACC_W:0]     sum_ext_s;
  logic [ACC_W-1:0]   acc_upd_s;
  logic [COUNT_W-1:0] cnt_upd_s;
  logic               ovf_upd_s;
  logic               accept_s;

  // in_ready is forced low during reset, so it cannot wait for a register.
  assign in_ready = (state_q == ST_ACCUM) && !rst;
  assign accept_s = in_valid && in_ready;

  // Running values that include the current beat (used on accept).
  assign sum_ext_s = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);
  assign acc_upd_s = sum_ext_s[ACC_W-1:0];
  assign ovf_upd_s = ovf_q | sum_ext_s[ACC_W];
  assign cnt_upd_s = sat_inc(cnt_q);

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Next-state logic: accumulate, close packets, release held results.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ST_ACCUM: begin
        if (flush) begin
          // Flush wins over a same-cycle beat, even a closing one.
          acc_d = {ACC_W{1'b0}};
          cnt_d = {COUNT_W{1'b0}};
          ovf_d = 1'b0;
        end else if (accept_s) begin
          if (in_last) begin
            // Result includes the closing beat; the accumulator restarts.
            out_sum_d   = acc_upd_s;
            out_count_d = cnt_upd_s;
            out_ovf_d   = ovf_upd_s;
            out_valid_d = 1'b1;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {COUNT_W{1'b0}};
            ovf_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_upd_s;
            cnt_d = cnt_upd_s;
            ovf_d = ovf_upd_s;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end

      ST_HOLD: begin
        // Flush and input beats are ignored here; only the output
        // handshake moves the block back to ACCUM.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d     = ST_ACCUM;
        acc_d       = {ACC_W{1'b0}};
        cnt_d       = {COUNT_W{1'b0}};
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {COUNT_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_count_q <= {COUNT_W{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_dadda_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_dadda_prod_accum
//
// Two instances share one stimulus stream: a default one (ACC_W=32,
// COUNT_W=8) and a narrow one (ACC_W=17, COUNT_W=2) where wrap, overflow and
// count saturation are easy to reach. Handshake behaviour does not depend on
// the widths, so both see identical acceptance timing.
// -----------------------------------------------------------------------------
module tb_dadda_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = 16'h0000;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [31:0] out_sum_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [16:0] out_sum_b;
  logic [1:0]  out_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] pkt[$];

  always #5 clk = ~clk;

  dadda_prod_accum u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .in_last(in_last), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  dadda_prod_accum #(.PROD_W(16), .ACC_W(17), .COUNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .in_last(in_last), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  typedef struct packed {
    logic [8:0]        n;
    logic [0:4][15:0]  p;
    logic [3:0]        hold;
    logic [31:0]       sum_a;
    logic [7:0]        cnt_a;
    logic              ovf_a;
    logic [16:0]       sum_b;
    logic [1:0]        cnt_b;
    logic              ovf_b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [15:0] p, input logic l);
    int t;
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    t = 0;
    @(negedge clk);
    while (!in_ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_a) chk("accept_timeout", {63'd0, in_ready_a}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = 16'($urandom);
  endtask

  task automatic send_packet();
    for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], (i == pkt.size() - 1));
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] sa, input logic [7:0] ca,
                             input logic oa, input logic [16:0] sb, input logic [1:0] cb,
                             input logic ob);
    chk({tag, "_valid_a"}, {63'd0, out_valid_a}, 64'd1);
    chk({tag, "_valid_b"}, {63'd0, out_valid_b}, 64'd1);
    chk({tag, "_in_ready"}, {63'd0, in_ready_a}, 64'd0);
    chk({tag, "_sum_a"}, {32'd0, out_sum_a}, {32'd0, sa});
    chk({tag, "_cnt_a"}, {56'd0, out_count_a}, {56'd0, ca});
    chk({tag, "_ovf_a"}, {63'd0, out_ovf_a}, {63'd0, oa});
    chk({tag, "_sum_b"}, {47'd0, out_sum_b}, {47'd0, sb});
    chk({tag, "_cnt_b"}, {62'd0, out_count_b}, {62'd0, cb});
    chk({tag, "_ovf_b"}, {63'd0, out_ovf_b}, {63'd0, ob});
  endtask

  // Called right after the last beat's accepting edge: the result must be
  // visible now (one-cycle latency), stay put under backpressure while
  // junk beats and flushes are offered, then be released by out_ready.
  task automatic check_result(input string tag, input int hold,
                              input logic [31:0] sa, input logic [7:0] ca, input logic oa,
                              input logic [16:0] sb, input logic [1:0] cb, input logic ob);
    @(negedge clk);
    chk_outputs(tag, sa, ca, oa, sb, cb, ob);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
      flush    = 1'($urandom);
      @(negedge clk);
      chk_outputs({tag, "_hold"}, sa, ca, oa, sb, cb, ob);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rel_valid_a"}, {63'd0, out_valid_a}, 64'd0);
    chk({tag, "_rel_valid_b"}, {63'd0, out_valid_b}, 64'd0);
    chk({tag, "_rel_in_ready"}, {63'd0, in_ready_a}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Reference: the packet total as a plain integer, then reduced per width.
  task automatic model_and_check(input string tag, input int hold);
    longint total;
    int n;
    total = 0;
    n = pkt.size();
    foreach (pkt[i]) total += longint'(pkt[i]);
    check_result(tag, hold,
                 32'(total % (64'd1 << 32)), 8'((n > 255) ? 255 : n), (total >= (64'd1 << 32)),
                 17'(total % (64'd1 << 17)), 2'((n > 3) ? 3 : n), (total >= (64'd1 << 17)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{9'd1, {16'hFE01, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd0,
                32'h0000FE01, 8'd1, 1'b0, 17'h0FE01, 2'd1, 1'b0};
    vecs[1] = '{9'd3, {16'd15, 16'd63, 16'd65025, 16'h0, 16'h0}, 4'd5,
                32'h0000FE4F, 8'd3, 1'b0, 17'h0FE4F, 2'd3, 1'b0};
    vecs[2] = '{9'd4, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0}, 4'd1,
                32'h0003FFFC, 8'd4, 1'b0, 17'h1FFFC, 2'd3, 1'b1};
    vecs[3] = '{9'd2, {16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0}, 4'd0,
                32'h00010000, 8'd2, 1'b0, 17'h10000, 2'd2, 1'b0};
    vecs[4] = '{9'd5, {16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01}, 4'd2,
                32'h0004F605, 8'd5, 1'b0, 17'h0F605, 2'd3, 1'b1};
    vecs[5] = '{9'd1, {16'h0001, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd0,
                32'h00000001, 8'd1, 1'b0, 17'h00001, 2'd1, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready_a}, 64'd0);
    chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
    chk("rst_sum", {32'd0, out_sum_a}, 64'd0);
    chk("rst_cnt", {56'd0, out_count_a}, 64'd0);
    chk("rst_ovf", {63'd0, out_ovf_a}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("post_rst_valid", {63'd0, out_valid_b}, 64'd0);
    @(posedge clk);
    #1;

    // Table-driven packets.
    for (int i = 0; i < 6; i++) begin
      pkt.delete();
      for (int j = 0; j < int'(vecs[i].n); j++) pkt.push_back(vecs[i].p[j]);
      send_packet();
      check_result($sformatf("vec%0d", i), int'(vecs[i].hold),
                   vecs[i].sum_a, vecs[i].cnt_a, vecs[i].ovf_a,
                   vecs[i].sum_b, vecs[i].cnt_b, vecs[i].ovf_b);
    end

    // Flush together with a closing beat drops the whole packet.
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    in_valid = 1'b1;
    in_prod  = 16'd300;
    in_last  = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_valid", {63'd0, out_valid_a}, 64'd0);
      chk("flush_in_ready", {63'd0, in_ready_a}, 64'd1);
    end
    @(posedge clk);
    #1;
    pkt.delete();
    pkt.push_back(16'd7);
    send_packet();
    check_result("after_flush", 0, 32'd7, 8'd1, 1'b0, 17'd7, 2'd1, 1'b0);

    // Asynchronous reset while a result is held.
    send_beat(16'd5, 1'b1);
    @(negedge clk);
    chk("hold_before_rst", {63'd0, out_valid_a}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid_a", {63'd0, out_valid_a}, 64'd0);
    chk("async_rst_valid_b", {63'd0, out_valid_b}, 64'd0);
    chk("async_rst_sum", {32'd0, out_sum_a}, 64'd0);
    chk("async_rst_cnt", {56'd0, out_count_a}, 64'd0);
    chk("async_rst_in_ready", {63'd0, in_ready_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rerst_in_ready", {63'd0, in_ready_a}, 64'd1);
    @(posedge clk);
    #1;
    pkt.delete();
    pkt.push_back(16'd9);
    send_packet();
    check_result("after_async_rst", 0, 32'd9, 8'd1, 1'b0, 17'd9, 2'd1, 1'b0);

    // Randomized packets against the arithmetic model.
    for (int r = 0; r < 30; r++) begin
      int n;
      pkt.delete();
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) pkt.push_back(16'hFFFF);
        else pkt.push_back(16'($urandom_range(0, 65535)));
      end
      send_packet();
      model_and_check($sformatf("rnd%0d", r), $urandom_range(0, 3));
    end

    // Long packet saturates the 8-bit count.
    pkt.delete();
    for (int j = 0; j < 260; j++) pkt.push_back(16'($urandom_range(0, 65535)));
    send_packet();
    model_and_check("long_pkt", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
